// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude comparator sequencer, MSB first.
// One compare cell is reused per clock; the lt/gt chain is held in flops.
module serial_comp_ctrl #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic                       busy,
    output logic                       done,
    output logic                       lt,
    output logic                       gt,
    output logic                       eq,
    output logic [$clog2(WIDTH):0]     bits_used
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic            sgn_r;
    logic            p_lt;
    logic            p_gt;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   count;

    logic            abit;
    logic            bbit;
    logic            nl;
    logic            ng;
    logic            finish;

    // Compare cell for the current bit plus next-state selection.
    always_comb begin
        abit    = a_r[idx];
        bbit    = b_r[idx];
        state_n = state;
        // Sign bit of 1 marks the smaller operand, so swap roles at the MSB.
        if (sgn_r && (idx == MSB_IDX)) begin
            abit = b_r[idx];
            bbit = a_r[idx];
        end
        nl     = ~p_gt & (p_lt | (~abit & bbit));
        ng     = ~p_lt & (p_gt | (abit & ~bbit));
        finish = ((EARLY_EXIT != 0) && (nl | ng)) || (idx == '0);
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN:  if (finish) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Operand latch, propagate chain and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r       <= '0;
            b_r       <= '0;
            sgn_r     <= 1'b0;
            p_lt      <= 1'b0;
            p_gt      <= 1'b0;
            idx       <= '0;
            count     <= '0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            bits_used <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a_in;
                        b_r   <= b_in;
                        sgn_r <= signed_mode;
                        p_lt  <= 1'b0;
                        p_gt  <= 1'b0;
                        idx   <= MSB_IDX;
                        count <= '0;
                    end
                end
                RUN: begin
                    p_lt  <= nl;
                    p_gt  <= ng;
                    count <= count + 1'b1;
                    idx   <= idx - 1'b1;
                    // Results load on the edge entering DONE so they
                    // are valid together with the done pulse.
                    if (finish) begin
                        lt        <= nl;
                        gt        <= ng;
                        eq        <= ~nl & ~ng;
                        bits_used <= count + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed bench for serial_comp_ctrl: early-exit and full-length
// instances, signed/unsigned compares, ignored start and reset abort.
module tb_serial_comp_ctrl;

    logic       clk;
    logic       reset;
    logic       start1;
    logic       start0;
    logic       signed_mode;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic       busy1, done1, lt1, gt1, eq1;
    logic [3:0] bu1;
    logic       busy0, done0, lt0, gt0, eq0;
    logic [3:0] bu0;

    int checks;
    int errors;

    serial_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .reset(reset), .start(start1),
        .signed_mode(signed_mode), .a_in(a_in), .b_in(b_in),
        .busy(busy1), .done(done1), .lt(lt1), .gt(gt1), .eq(eq1),
        .bits_used(bu1)
    );

    serial_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .reset(reset), .start(start0),
        .signed_mode(signed_mode), .a_in(a_in), .b_in(b_in),
        .busy(busy0), .done(done0), .lt(lt0), .gt(gt0), .eq(eq0),
        .bits_used(bu0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmp(input string tag, input bit ee,
                           input logic [7:0] a, input logic [7:0] b,
                           input bit s, input bit elt, input bit egt,
                           input bit eeq, input int ebu, input int elat,
                           input bit pulse);
        int  n;
        int  bcnt;
        bit  got;
        logic o_lt, o_gt, o_eq, o_done;
        logic [3:0] o_bu;
        @(negedge clk);
        a_in = a;
        b_in = b;
        signed_mode = s;
        if (ee) start1 = 1'b1;
        else    start0 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start0 = 1'b0;
        a_in = ~a;
        b_in = ~b;
        signed_mode = ~s;
        n = 0;
        bcnt = 0;
        got = 1'b0;
        @(negedge clk);
        if (ee ? busy1 : busy0) bcnt++;
        while (!got && n < 20) begin
            if (pulse && n == 2) begin
                start1 = 1'b1;
                a_in = 8'h00;
                b_in = 8'hFF;
            end
            @(posedge clk);
            n++;
            #1;
            start1 = 1'b0;
            @(negedge clk);
            o_done = ee ? done1 : done0;
            if (o_done) got = 1'b1;
            else if (ee ? busy1 : busy0) bcnt++;
        end
        o_lt = ee ? lt1 : lt0;
        o_gt = ee ? gt1 : gt0;
        o_eq = ee ? eq1 : eq0;
        o_bu = ee ? bu1 : bu0;
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_lt"}, o_lt, elt);
        chk({tag, "_gt"}, o_gt, egt);
        chk({tag, "_eq"}, o_eq, eeq);
        chk({tag, "_bits_used"}, o_bu, ebu);
        chk({tag, "_busy_cycles"}, bcnt, elat);
        chk({tag, "_busy_in_done"}, ee ? busy1 : busy0, 0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, ee ? done1 : done0, 0);
        chk({tag, "_hold_lt"}, ee ? lt1 : lt0, elt);
    endtask

    initial begin
        int dcnt;
        int bcnt2;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start1 = 1'b0;
        start0 = 1'b0;
        signed_mode = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_flags", {lt1, gt1, eq1}, 0);
        chk("rst_bits", bu1, 0);
        chk("rst_full_flags", {busy0, done0, lt0, gt0, eq0}, 0);
        reset = 1'b0;

        run_cmp("u80_7f", 1, 8'h80, 8'h7F, 0, 0, 1, 0, 1, 1, 0);
        run_cmp("s80_7f", 1, 8'h80, 8'h7F, 1, 1, 0, 0, 1, 1, 0);
        run_cmp("sff_01", 1, 8'hFF, 8'h01, 1, 1, 0, 0, 1, 1, 0);
        run_cmp("s01_ff", 1, 8'h01, 8'hFF, 1, 0, 1, 0, 1, 1, 0);
        run_cmp("u5a_5a", 1, 8'h5A, 8'h5A, 0, 0, 0, 1, 8, 8, 0);
        run_cmp("u12_13", 1, 8'h12, 8'h13, 0, 1, 0, 0, 8, 8, 0);
        run_cmp("full_f0_0f", 0, 8'hF0, 8'h0F, 0, 0, 1, 0, 8, 8, 0);

        run_cmp("ign_01_02", 1, 8'h01, 8'h02, 0, 1, 0, 0, 7, 7, 1);
        dcnt = 0;
        bcnt2 = 0;
        repeat (12) begin
            @(negedge clk);
            if (done1) dcnt++;
            if (busy1) bcnt2++;
        end
        chk("ign_no_second_done", dcnt, 0);
        chk("ign_no_second_busy", bcnt2, 0);

        @(negedge clk);
        a_in = 8'h01;
        b_in = 8'h02;
        signed_mode = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_flags", {lt1, gt1, eq1}, 0);
        chk("abort_bits", bu1, 0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done1) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        run_cmp("after_03_03", 1, 8'h03, 8'h03, 0, 0, 0, 1, 8, 8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comp_ctrl.md
Name: serial_comp_ctrl

Overview:
- Sequencer that shares a single 1-bit magnitude-compare cell across a WIDTH-bit operand pair, one bit per clock, MSB-first.
- The cell's less/greater propagate chain is held in registers between cycles.
- Exits early once the result is decided; supports unsigned and two's-complement compare.
- Sits between a requesting unit (start/done handshake) and the 1-bit compare datapath; results are registered and held.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- EARLY_EXIT, 1, 1 = finish as soon as lt or gt is set; 0 = always process all WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- signed_mode  input  1  sampled with start; 1 = two's-complement compare.
- a_in  input  WIDTH  operand A, sampled with start.
- b_in  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- lt  output  1  A < B.
- gt  output  1  A > B.
- eq  output  1  A == B.
- bits_used  output  log2(WIDTH)+1  number of bit positions examined by the last compare.

Behaviour:
- Reset values (reset sampled high at an edge): state IDLE; busy=0, done=0, lt=0, gt=0, eq=0, bits_used=0. Internal p_lt, p_gt, idx and operand registers are cleared.
- Reset overrides everything, including a compare in progress. No done is produced for an aborted compare.
- States:
  - IDLE: start=1 at edge E0 latches a_in, b_in and signed_mode; clears p_lt/p_gt; sets idx=WIDTH-1 and count=0; goes to RUN. start=0: stay in IDLE.
  - RUN: each edge evaluates bit idx with the cell equations:
    - nl = ~p_gt & (p_lt | (~a & b))
    - ng = ~p_lt & (p_gt | (a & ~b))
    - Then p_lt<=nl, p_gt<=ng, count<=count+1, idx<=idx-1.
  - Signed MSB rule: when signed_mode=1 and idx==WIDTH-1, the MSB roles are swapped (a and b exchanged in the equations). A sign bit of 1 means the smaller operand.
  - RUN -> DONE when (EARLY_EXIT=1 and (nl|ng)) or idx==0. Otherwise stay in RUN.
  - DONE: done=1 for exactly one cycle. lt<=p_lt, gt<=p_gt, eq<=~p_lt&~p_gt and bits_used<=count are registered on entry, so they are valid in the same cycle done is high. Then DONE -> IDLE.
- lt/gt/eq/bits_used hold until the next done. Exactly one of lt/gt/eq is 1 after the first completed compare.
- Latency (start sampled at E0, k = number of equal leading bits):
  - Early exit: done is high in the cycle after edge E(k+1).
  - Equal operands or EARLY_EXIT=0: done is high in the cycle after edge E(WIDTH).
  - bits_used = k+1, or WIDTH in the full-length case.
- busy=1 from the cycle after E0 through the last RUN cycle. busy=0 in DONE.
- start while busy or in DONE is ignored: not queued, and operands are not re-sampled.
- Operand inputs may change freely after E0. Only the latched copies are used.
- p_lt and p_gt are never both 1. Once either is set it is never cleared within an operation; this follows from the equations.

Test Plan:
- WIDTH=8, unsigned, a=0x80, b=0x7F -> gt=1, lt=0, eq=0, bits_used=1, done high in the cycle after E1.
- Same operands, signed_mode=1 -> lt=1, bits_used=1, done in the cycle after E1. Also a=0xFF (-1), b=0x01 signed -> lt=1. a=0x01, b=0xFF signed -> gt=1.
- a=0x5A, b=0x5A -> eq=1, bits_used=8, done in the cycle after E8. Then a=0x12, b=0x13 -> lt=1, bits_used=8, done in the cycle after E8.
- EARLY_EXIT=0, a=0xF0, b=0x0F -> gt=1, bits_used=8, done only in the cycle after E8. busy stays high for 8 cycles.
- start pulsed again during RUN with new operands (0x00, 0xFF) -> ignored. The first result and latency are unchanged, exactly one done pulse, and no second compare follows.
- Start a=0x01, b=0x02 (EARLY_EXIT=1), assert reset at E3 -> busy=0, done=0, lt=gt=eq=0 after E3, no done. A subsequent start a=0x03, b=0x03 completes with eq=1 in the cycle after E8 relative to its own start edge.
